// File: rtl/cv32e40p_pkg.sv
// Shared types for the OBI instruction-port arbiter and its ID tracking FIFO.
package cv32e40p_pkg;

    typedef enum logic {
        IREQ_PREFETCH = 1'b0,
        IREQ_AUX      = 1'b1
    } instr_req_id_e;

    localparam int unsigned IREQ_NUM = 2;

    function automatic instr_req_id_e other_req(input instr_req_id_e id);
        return (id == IREQ_AUX) ? IREQ_PREFETCH : IREQ_AUX;
    endfunction

endpackage

// File: rtl/cv32e40p_obi_id_fifo.sv
// In-order FIFO of requester IDs for granted-but-unanswered OBI transactions.
module cv32e40p_obi_id_fifo
    import cv32e40p_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             push_i,
    input  logic                             pop_i,
    input  instr_req_id_e                    id_i,
    output instr_req_id_e                    id_head_o,
    output logic [$clog2(DEPTH+1)-1:0]       count_o
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    instr_req_id_e      mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    // Pointers wrap at DEPTH (not a power of two in general); full/empty come from the count.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop_i) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= id_i;
        end
    end

    assign id_head_o = mem_q[rd_ptr_q];
    assign count_o   = count_q;

endmodule

// File: rtl/cv32e40p_obi_instr_arbiter.sv
// Round-robin arbiter sharing one OBI instruction port between the prefetch
// buffer and an auxiliary fetcher, with in-order response routing.
module cv32e40p_obi_instr_arbiter
    import cv32e40p_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  r_req_i,
    input  logic [31:0] r_addr0_i,
    input  logic [31:0] r_addr1_i,
    output logic [1:0]  r_gnt_o,
    output logic [1:0]  r_rvalid_o,
    output logic [31:0] r_rdata_o,
    output logic        r_err_o,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    input  logic        instr_err_i,
    output logic        busy_o,
    output logic        protocol_err_o
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    instr_req_id_e    ptr_q, ptr_d;
    logic             lock_q, lock_d;
    instr_req_id_e    lock_id_q, lock_id_d;
    logic             perr_q, perr_d;

    instr_req_id_e    winner;
    logic             winner_req;
    logic             gate_open;
    logic             handshake;
    logic             pop;
    logic             outstanding;
    instr_req_id_e    head_id;
    logic [CNT_W-1:0] count;

    cv32e40p_obi_id_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_i    (handshake),
        .pop_i     (pop),
        .id_i      (winner),
        .id_head_o (head_id),
        .count_o   (count)
    );

    // Gate uses the registered count only, so rvalid never feeds instr_req_o.
    assign gate_open   = (count < MAX_CNT);
    assign outstanding = (count != '0);

    always_comb begin
        winner     = ptr_q;
        winner_req = 1'b0;
        if (lock_q) begin
            winner     = lock_id_q;
            winner_req = r_req_i[lock_id_q];
        end else begin
            case (r_req_i)
                2'b01: begin
                    winner     = IREQ_PREFETCH;
                    winner_req = 1'b1;
                end
                2'b10: begin
                    winner     = IREQ_AUX;
                    winner_req = 1'b1;
                end
                2'b11: begin
                    winner     = ptr_q;
                    winner_req = 1'b1;
                end
                default: begin
                    winner     = ptr_q;
                    winner_req = 1'b0;
                end
            endcase
        end
    end

    assign instr_req_o  = !rst && gate_open && winner_req;
    assign instr_addr_o = (winner == IREQ_AUX) ? r_addr1_i : r_addr0_i;
    assign handshake    = instr_req_o && instr_gnt_i;
    assign pop          = !rst && instr_rvalid_i && outstanding;

    generate
        for (genvar gi = 0; gi < IREQ_NUM; gi++) begin : g_route
            assign r_gnt_o[gi]    = handshake && (winner == instr_req_id_e'(1'(gi)));
            assign r_rvalid_o[gi] = pop && (head_id == instr_req_id_e'(1'(gi)));
        end
    endgenerate

    assign r_rdata_o      = instr_rdata_i;
    assign r_err_o        = instr_err_i;
    assign busy_o         = instr_req_o || outstanding;
    assign protocol_err_o = perr_q;

    // A stalled address phase locks the winner; a dropped request also clears the lock.
    always_comb begin
        ptr_d     = handshake ? other_req(winner) : ptr_q;
        lock_d    = instr_req_o && !instr_gnt_i;
        lock_id_d = lock_d ? winner : lock_id_q;
        perr_d    = perr_q || (instr_rvalid_i && !outstanding);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q     <= IREQ_PREFETCH;
            lock_q    <= 1'b0;
            lock_id_q <= IREQ_PREFETCH;
            perr_q    <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
            perr_q    <= perr_d;
        end
    end

endmodule
